// File: rtl/itof_pipe_if.sv
// Valid/ready bundle for the int-to-float pipe: operand side (in_*, x) and result side (out_*, y).
interface itof_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage elastic signed int32 -> IEEE-754 single converter (capture, normalize, round/pack).
// Define ITOF_RNE_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module itof_pipe (
    input  logic        clk,
    input  logic        rstn,
    itof_pipe_if.slave  bus
);

    logic        r_v1, r_s1, r_z1;
    logic [31:0] r_a1;
    logic        r_v2, r_s2, r_z2;
    logic [31:0] r_n2;
    logic [7:0]  r_e2;
    logic        r_v3;
    logic [31:0] r_y3;

    logic        w_en1, w_en2, w_en3;
    logic [4:0]  w_lz;
    logic [23:0] w_sig;
    logic        w_r;
    logic [24:0] w_sum;
    logic [7:0]  w_e3;
    logic        w_unused;

    // A stage can load when it is empty or its contents move on this cycle.
    assign w_en3 = !r_v3 | bus.out_ready;
    assign w_en2 = !r_v2 | w_en3;
    assign w_en1 = !r_v1 | w_en2;

    assign bus.in_ready  = w_en1;
    assign bus.out_valid = r_v3;
    assign bus.y         = r_y3;

    // Highest set bit wins because the scan runs upward.
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_a1[i]) w_lz = 5'(31 - i);
        end
    end

    assign w_sig = r_n2[31:8];

`ifdef ITOF_RNE_EN
    logic w_g, w_st;
    assign w_g      = r_n2[7];
    assign w_st     = |r_n2[6:0];
    assign w_r      = w_g & (w_st | w_sig[0]);
    assign w_unused = w_sum[23];
`else
    assign w_r      = 1'b0;
    // The bits below the significand only matter when rounding.
    assign w_unused = w_sum[23] ^ (^r_n2[7:0]);
`endif

    assign w_sum = {1'b0, w_sig} + {24'd0, w_r};
    assign w_e3  = r_e2 + {7'd0, w_sum[24]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            r_s1 <= 1'b0;
            r_z1 <= 1'b0;
            r_a1 <= 32'd0;
            r_v2 <= 1'b0;
            r_s2 <= 1'b0;
            r_z2 <= 1'b0;
            r_n2 <= 32'd0;
            r_e2 <= 8'd0;
            r_v3 <= 1'b0;
            r_y3 <= 32'd0;
        end else begin
            if (w_en1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1 <= bus.x[31];
                    r_a1 <= bus.x[31] ? (~bus.x + 32'd1) : bus.x;
                    r_z1 <= (bus.x == 32'd0);
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2 <= r_s1;
                    r_z2 <= r_z1;
                    r_n2 <= r_a1 << w_lz;
                    r_e2 <= 8'd158 - {3'd0, w_lz};
                end
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    // A carry out of the significand leaves the mantissa field all-zero.
                    r_y3 <= r_z2 ? 32'd0 : {r_s2, w_e3, w_sum[22:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed extremes, back-pressure, mid-run reset, and
// randomized traffic checked against an arithmetic reference conversion.
module tb_itof_pipe;

    logic clk = 1'b0;
    logic rstn;

    itof_pipe_if bus ();

    itof_pipe dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc    = 0;
    bit          chk_lat = 1'b0;
    bit          held_vld = 1'b0;
    logic [31:0] held_y;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference conversion from the value itself: find the top bit, keep 24 bits, round the rest.
    function automatic logic [31:0] ref_itof(input logic [31:0] xv);
        longint          sx;
        longint unsigned mag, q, rem, half;
        int              p, sh;
        logic            sgn;
        if (xv == 32'd0) return 32'd0;
        sx  = longint'($signed(xv));
        sgn = (sx < 0);
        mag = sgn ? longint'(-sx) : longint'(sx);
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
`ifdef ITOF_RNE_EN
            if (rem > half || (rem == half && q[0])) q++;
`endif
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p++;
            end
        end
        return {sgn, 8'(p + 127), q[22:0]};
    endfunction

    task automatic step(input logic v, input logic [31:0] xv, input logic [31:0] ev,
                        input logic ordy, output bit acc);
        int ac;
        logic [31:0] e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.x         = xv;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && ordy) begin
            held_vld = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                check("y", bus.y, e);
                if (chk_lat) check("latency", 32'(cyc - ac), 32'd3);
            end
        end else if (bus.out_valid && !ordy) begin
            if (held_vld) check("y_stable_in_stall", bus.y, held_y);
            held_vld = 1'b1;
            held_y   = bus.y;
        end
        acc = v && bus.in_ready;
        if (acc) begin
            exp_q.push_back(ev);
            acc_q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        bit a;
        int b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, a);
            b--;
        end
        check("drain_timeout_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit          a;
        int          sent;
        logic [31:0] xv;
        logic [31:0] dx[7];
        logic [31:0] dy[7];

        dx = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd16777217,
               32'd16777219};
`ifdef ITOF_RNE_EN
        dy = '{32'h0, 32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h4F00_0000,
               32'h4B80_0000, 32'h4B80_0002};
`else
        dy = '{32'h0, 32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h4EFF_FFFF,
               32'h4B80_0000, 32'h4B80_0001};
`endif

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_y", bus.y, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rstn = 1'b1;

        // Directed values back-to-back with no stalls: every result exactly 3 cycles later.
        chk_lat = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, dx[i], dy[i], 1'b1, a);
        drain(20);
        chk_lat = 1'b0;

        // Back-pressure: 10 operands, consumer stalled for stream cycles 2..8.
        sent = 0;
        for (int c = 0; c < 60 && (sent < 10 || exp_q.size() != 0); c++) begin
            xv = $urandom();
            step(sent < 10, xv, ref_itof(xv), !(c >= 2 && c <= 8), a);
            if (a) sent++;
            if (c == 3) begin
                check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                check("bp_accepts", 32'(sent), 32'd3);
            end
        end
        check("bp_sent", 32'(sent), 32'd10);
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // Reset with three results in flight.
        for (int i = 0; i < 3; i++) begin
            xv = $urandom() | 32'h1;
            step(1'b1, xv, ref_itof(xv), 1'b0, a);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_y", bus.y, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        acc_q.delete();
        held_vld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 32'd0, 1'b1, a);
        check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Randomized traffic with random valid/ready.
        sent = 0;
        for (int c = 0; c < 60000 && sent < 15000; c++) begin
            case ($urandom_range(0, 3))
                0:       xv = $urandom();
                1:       xv = $urandom() >> $urandom_range(0, 31);
                2:       xv = -($urandom() >> $urandom_range(0, 31));
                default: xv = (32'd1 << $urandom_range(24, 31)) + $urandom_range(0, 3)
                              - $urandom_range(0, 1);
            endcase
            step($urandom_range(0, 3) != 0, xv, ref_itof(xv), $urandom_range(0, 3) != 0, a);
            if (a) sent++;
        end
        check("rand_sent", 32'(sent), 32'd15000);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
